ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage directly downstream of the register file.
- Captures one instruction's read operands (d1/d2) plus decoded control, applies operand forwarding, and computes the result.
- Single-cycle ALU ops complete in 1 cycle. MUL runs on an iterative shift-add unit over N cycles.
- Presents a registered write-back request (out_wa/out_wd/out_we) to the downstream stage that drives the register file write port. Valid/ready handshake on both sides.

Parameters:
- N, 8, data width (matches register file data width).
- M, 2, register address width (2**M registers).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage accepts this cycle; transfer when in_valid && in_ready.
- op  in  3  operation code (see Behaviour).
- rs  in  M  source A register address (the address that produced d1).
- rt  in  M  source B register address (the address that produced d2).
- rd  in  M  destination register address.
- wr  in  1  instruction writes rd.
- d1  in  N  register file read data for rs.
- d2  in  N  register file read data for rt.
- imm  in  N  immediate operand.
- use_imm  in  1  B operand = imm instead of forwarded rt value.
- wb_we  in  1  write-back stage is writing the register file this cycle.
- wb_wa  in  M  write-back address.
- wb_wd  in  N  write-back data.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream consumes result; transfer when out_valid && out_ready.
- out_wa  out  M  destination address of held result.
- out_wd  out  N  held result.
- out_we  out  1  held result is to be written.

Behaviour:
- Opcodes (all arithmetic mod 2**N, result width N):
  - 000 ADD a+b
  - 001 SUB a-b
  - 010 AND
  - 011 OR
  - 100 SLT: 1 if signed a<b, else 0
  - 101 XOR
  - 110 MUL: low N bits of a*b
  - 111 SLL: a << b[2:0]
- Operand A, evaluated at acceptance, in priority order:
  1. out_wd if out_valid && out_we && out_wa==rs.
  2. Else wb_wd if wb_we && wb_wa==rs.
  3. Else d1.
- Operand B: imm if use_imm. Otherwise the same priority chain with rt and d2.
- No special handling of register address 0.
- FSM states:
  - IDLE: result register empty.
  - BUSY: multiply in progress.
  - HOLD: out_valid=1.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is 0 in BUSY.
- Accept of a non-MUL op from IDLE or HOLD:
  - Next cycle: HOLD, out_valid=1, out_wd=result, out_wa=rd, out_we=wr.
  - Latency 1 cycle. Back-to-back throughput of 1 op/cycle when out_ready stays high.
- Accept of MUL:
  - Latch the multiplicand, the multiplier, rd and wr. Clear the accumulator. Counter=0. Go to BUSY.
  - If coming from HOLD, out_valid drops to 0 the same edge, because the old result was consumed.
  - BUSY: each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left 1 and the multiplier right 1, and increment the counter.
  - After the N-th iteration, go to HOLD with the product.
  - Result visible N+1 cycles after the accept edge.
- HOLD with out_ready=1 and no accept: go to IDLE, out_valid=0.
- HOLD with out_ready=0: all outputs held stable. in_ready=0.
- Forwarding from the own result register uses its value even when it is being consumed in that same cycle.
- Reset (asynchronous, any time including mid-multiply):
  - State IDLE, out_valid=0, out_wa=0, out_wd=0, out_we=0.
  - Counter and accumulator = 0. An in-flight multiply is discarded.
  - in_ready=1 after reset deasserts.

Test Plan:
- Reset mid-multiply: MUL 7*9 accepted, rst asserted 3 cycles later -> out_valid=0, out_wd=0 immediately (asynchronous). After release, in_ready=1 and no result emerges.
- ALU ops with out_ready=1:
  - ADD 0x7F+0x01 -> out_wd=0x80 one cycle later.
  - SUB 0x00-0x01 -> 0xFF.
  - SLT 0xFF,0x01 -> 0x01.
  - SLL 0x81 by 3 -> 0x08.
- MUL latency: MUL 0x13*0x0B (d1=0x13, d2=0x0B) -> in_ready=0 for 8 cycles; out_valid rises 9 cycles after accept with out_wd=0xD1 (209 mod 256).
- Forwarding priority:
  - Held result r1=0x05 (out_valid, out_ready=0), wb writing r1=0x22, d1=0x99, rs=r1.
  - Accept ADD r1+imm 1 after out_ready goes high -> out_wd=0x06.
  - Repeat with out_valid=0 -> out_wd=0x23.
- Backpressure: out_ready=0 for 5 cycles with a valid result -> in_ready=0; out_wa/out_wd/out_we stable. Release -> new op accepted the same cycle.
- Stream: 4 consecutive ADDs with in_valid=1 and out_ready=1 -> one result per cycle, in order, correct rd on each.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: captures operands with forwarding, runs single-cycle ALU ops or an
// iterative shift-add multiply, and holds a registered write-back request for downstream.
module ex_stage #(
  parameter int N = 8,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [M-1:0] rs,
  input  logic [M-1:0] rt,
  input  logic [M-1:0] rd,
  input  logic         wr,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] imm,
  input  logic         use_imm,
  input  logic         wb_we,
  input  logic [M-1:0] wb_wa,
  input  logic [N-1:0] wb_wd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_wa,
  output logic [N-1:0] out_wd,
  output logic         out_we
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  state_t         state_q, state_d;
  logic [M-1:0]   out_wa_q, out_wa_d;
  logic [N-1:0]   out_wd_q, out_wd_d;
  logic           out_we_q, out_we_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   mul_rd_q, mul_rd_d;
  logic           mul_wr_q, mul_wr_d;

  logic           accept;
  logic           held_fwd;
  logic [N-1:0]   op_a, op_b, fwd_b, alu_res;

  assign out_valid = (state_q == HOLD);
  assign out_wa    = out_wa_q;
  assign out_wd    = out_wd_q;
  assign out_we    = out_we_q;
  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign held_fwd  = out_valid && out_we_q;

  // The held result wins over the write-back port even while it is being consumed.
  always_comb begin
    op_a = d1;
    if (held_fwd && (out_wa_q == rs))
      op_a = out_wd_q;
    else if (wb_we && (wb_wa == rs))
      op_a = wb_wd;

    fwd_b = d2;
    if (held_fwd && (out_wa_q == rt))
      fwd_b = out_wd_q;
    else if (wb_we && (wb_wa == rt))
      fwd_b = wb_wd;
    op_b = use_imm ? imm : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_SLT:  alu_res = ($signed(op_a) < $signed(op_b)) ? N'(1) : '0;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << op_b[2:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    out_wa_d = out_wa_q;
    out_wd_d = out_wd_q;
    out_we_d = out_we_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_rd_d = mul_rd_q;
    mul_wr_d = mul_wr_q;

    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
            mul_rd_d = rd;
            mul_wr_d = wr;
            state_d  = BUSY;
          end else begin
            out_wd_d = alu_res;
            out_wa_d = rd;
            out_we_d = wr;
            state_d  = HOLD;
          end
        end else if ((state_q == HOLD) && out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // N shift-add iterations, then one more cycle to publish the product.
        if (cnt_q == CW'(N)) begin
          out_wd_d = acc_q;
          out_wa_d = mul_rd_q;
          out_we_d = mul_wr_q;
          state_d  = HOLD;
        end else begin
          if (mplier_q[0])
            acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      out_wa_q <= '0;
      out_wd_q <= '0;
      out_we_q <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mul_rd_q <= '0;
      mul_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_wa_q <= out_wa_d;
      out_wd_q <= out_wd_d;
      out_we_q <= out_we_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mul_rd_q <= mul_rd_d;
      mul_wr_q <= mul_wr_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, multiply latency, forwarding priority,
// backpressure, streaming and asynchronous reset during a multiply.
module tb_ex_stage;

  localparam int N = 8;
  localparam int M = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [2:0]   op;
  logic [M-1:0] rs, rt, rd;
  logic         wr;
  logic [N-1:0] d1, d2, imm;
  logic         use_imm;
  logic         wb_we;
  logic [M-1:0] wb_wa;
  logic [N-1:0] wb_wd;
  logic         out_valid, out_ready;
  logic [M-1:0] out_wa;
  logic [N-1:0] out_wd;
  logic         out_we;

  int compareCount = 0;
  int failCount    = 0;

  ex_stage #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .wr(wr),
    .d1(d1), .d2(d2), .imm(imm), .use_imm(use_imm),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wa(out_wa), .out_wd(out_wd), .out_we(out_we)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [M-1:0] a,
                               input logic [M-1:0] b, input logic [M-1:0] dst, input logic w,
                               input logic [N-1:0] x1, input logic [N-1:0] x2,
                               input logic [N-1:0] im, input logic ui);
    in_valid = v;  op = o;  rs = a;  rt = b;  rd = dst;  wr = w;
    d1 = x1;  d2 = x2;  imm = im;  use_imm = ui;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int leaks;
    rst = 1'b1;  out_ready = 1'b1;
    wb_we = 1'b0;  wb_wa = '0;  wb_wd = '0;
    applyStimulus(1'b0, 3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("reset_valid", out_valid, 1'b0);
    checkOutput("reset_wd", out_wd, 8'h00);
    checkOutput("reset_wa", out_wa, 2'd0);
    checkOutput("reset_we", out_we, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", in_ready, 1'b1);

    // Single-cycle ALU ops, destinations chosen so nothing forwards
    applyStimulus(1'b1, 3'b000, 2'd0, 2'd1, 2'd2, 1'b1, 8'h7F, 8'h01, 8'h00, 1'b0);
    tick();
    checkOutput("add_valid", out_valid, 1'b1);
    checkOutput("add_wd", out_wd, 8'h80);
    checkOutput("add_wa", out_wa, 2'd2);
    checkOutput("add_we", out_we, 1'b1);
    applyStimulus(1'b1, 3'b001, 2'd0, 2'd1, 2'd3, 1'b1, 8'h00, 8'h01, 8'h00, 1'b0);
    tick();
    checkOutput("sub_wd", out_wd, 8'hFF);
    checkOutput("sub_wa", out_wa, 2'd3);
    applyStimulus(1'b1, 3'b100, 2'd0, 2'd1, 2'd1, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b0);
    tick();
    checkOutput("slt_wd", out_wd, 8'h01);
    checkOutput("slt_we", out_we, 1'b0);
    applyStimulus(1'b1, 3'b111, 2'd0, 2'd1, 2'd2, 1'b1, 8'h81, 8'h00, 8'h03, 1'b1);
    tick();
    checkOutput("sll_wd", out_wd, 8'h08);
    applyStimulus(1'b1, 3'b101, 2'd0, 2'd1, 2'd3, 1'b1, 8'hF0, 8'h3C, 8'h00, 1'b0);
    tick();
    checkOutput("xor_wd", out_wd, 8'hCC);

    // Reset three cycles into a multiply accepted from HOLD
    applyStimulus(1'b1, 3'b110, 2'd0, 2'd1, 2'd1, 1'b1, 8'h07, 8'h09, 8'h00, 1'b0);
    tick();
    checkOutput("mul_from_hold_valid", out_valid, 1'b0);
    checkOutput("mul_busy_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", out_valid, 1'b0);
    checkOutput("async_rst_wd", out_wd, 8'h00);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1'b1);
    leaks = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) leaks++;
    end
    checkOutput("post_rst_no_result", leaks, 0);

    // Multiply latency: product appears N+1 edges after the accept edge
    applyStimulus(1'b1, 3'b110, 2'd0, 2'd1, 2'd3, 1'b1, 8'h13, 8'h0B, 8'h00, 1'b0);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("mul_accept_in_ready", in_ready, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput($sformatf("mul_wait%0d", i), {in_ready, out_valid}, 2'b00);
    end
    tick();
    checkOutput("mul_valid", out_valid, 1'b1);
    checkOutput("mul_wd", out_wd, 8'hD1);
    checkOutput("mul_wa", out_wa, 2'd3);

    // Backpressure with a pending instruction waiting
    applyStimulus(1'b1, 3'b000, 2'd0, 2'd1, 2'd1, 1'b1, 8'h01, 8'h02, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("bp_in_ready%0d", i), in_ready, 1'b0);
      tick();
      checkOutput($sformatf("bp_hold%0d", i), {out_valid, out_we, out_wa, out_wd},
                  {1'b1, 1'b1, 2'd3, 8'hD1});
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_in_ready", in_ready, 1'b1);
    tick();
    checkOutput("bp_release_wd", out_wd, 8'h03);
    checkOutput("bp_release_wa", out_wa, 2'd1);

    // Forwarding priority: held result beats write-back beats register data
    applyStimulus(1'b1, 3'b000, 2'd2, 2'd3, 2'd1, 1'b1, 8'h05, 8'h00, 8'h00, 1'b0);
    tick();
    checkOutput("fwd_setup_wd", out_wd, 8'h05);
    out_ready = 1'b0;
    in_valid = 1'b0;
    tick();
    wb_we = 1'b1;  wb_wa = 2'd1;  wb_wd = 8'h22;
    applyStimulus(1'b1, 3'b000, 2'd1, 2'd0, 2'd2, 1'b1, 8'h99, 8'h00, 8'h01, 1'b1);
    #1;
    checkOutput("fwd_wait_in_ready", in_ready, 1'b0);
    tick();
    out_ready = 1'b1;
    tick();
    checkOutput("fwd_held_wd", out_wd, 8'h06);
    checkOutput("fwd_held_wa", out_wa, 2'd2);
    in_valid = 1'b0;
    tick();
    checkOutput("fwd_idle_valid", out_valid, 1'b0);
    in_valid = 1'b1;
    tick();
    checkOutput("fwd_wb_wd", out_wd, 8'h23);
    wb_we = 1'b0;
    rs = 2'd0;
    tick();
    checkOutput("fwd_d1_wd", out_wd, 8'h9A);
    // Operand B through the write-back port
    wb_we = 1'b1;  wb_wa = 2'd3;  wb_wd = 8'h10;
    applyStimulus(1'b1, 3'b000, 2'd0, 2'd3, 2'd1, 1'b1, 8'h01, 8'h77, 8'h00, 1'b0);
    tick();
    checkOutput("fwd_b_wb_wd", out_wd, 8'h11);
    wb_we = 1'b0;

    // Stream of four ADDs, one result per cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'b000, 2'd0, 2'd0, 2'((i % 3) + 1), 1'b1,
                    8'(16 * i + 1), 8'(i), 8'h00, 1'b0);
      #1;
      checkOutput($sformatf("stream_in_ready%0d", i), in_ready, 1'b1);
      tick();
      checkOutput($sformatf("stream%0d", i), {out_valid, out_wa, out_wd},
                  {1'b1, 2'((i % 3) + 1), 8'(16 * i + 1 + i)});
    end
    in_valid = 1'b0;
    tick();
    checkOutput("stream_drain_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
